// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, FSM state type and opcode decode helpers for the serial ALU
package alu_pkg;

    localparam logic [3:0] OP_INC = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_DEC = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0100;
    localparam logic [3:0] OP_OR  = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_SHR = 4'b1000;
    localparam logic [3:0] OP_SHL = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_shift(input logic [3:0] sel);
        return sel[3];
    endfunction

    function automatic logic is_arith(input logic [3:0] sel);
        return sel[3:2] == 2'b00;
    endfunction

endpackage

// File: rtl/alu_1bit.sv
// alu_1bit: one-bit ALU slice for the arithmetic (sel[2]=0) and logic (sel[2]=1) opcodes
module alu_1bit (
    input  logic       a_i,
    input  logic       b_i,
    input  logic       cin_i,
    input  logic [2:0] sel_i,
    output logic       f_o,
    output logic       cout_o
);

    logic y;

    // select the second adder operand, then form sum/logic result and carry
    always_comb begin
        y      = sel_i[1] ? (sel_i[0] ? 1'b1 : ~b_i) : (sel_i[0] ? b_i : 1'b0);
        f_o    = sel_i[2] ? (sel_i[1] ? (sel_i[0] ? ~a_i : a_i ^ b_i)
                                      : (sel_i[0] ? a_i | b_i : a_i & b_i))
                          : a_i ^ y ^ cin_i;
        cout_o = ~sel_i[2] & ((a_i & y) | (cin_i & (a_i ^ y)));
    end

endmodule

// File: rtl/alu_serial.sv
// alu_serial: bit-serial ALU with valid/ready handshake; shifts finish in one cycle
module alu_serial
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    input  logic [3:0]       sel_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] f_o,
    output logic             cout_o,
    output logic             zero_o,
    output logic             ovf_o
);

    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, f_q, f_d;
    logic [WIDTH-1:0] res_next, shift_val;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       sel_q, sel_d;
    logic             carry_q, carry_d, cout_q, cout_d, zero_q, zero_d, ovf_q, ovf_d;
    logic             bit_f, bit_c, last_bit;

    alu_1bit u_bit (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .cin_i (carry_q),
        .sel_i (sel_q[2:0]),
        .f_o   (bit_f),
        .cout_o(bit_c)
    );

    // next state: capture on accept, shift operands LSB first through the slice, publish on completion
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        carry_d   = carry_q;
        f_d       = f_q;
        cout_d    = cout_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        res_next  = {bit_f, res_q[WIDTH-1:1]};
        shift_val = sel_q[2] ? {a_q[WIDTH-2:0], 1'b0} : {1'b0, a_q[WIDTH-1:1]};
        last_bit  = cnt_q == CW'(WIDTH - 1);
        if (state_q == IDLE) begin
            if (in_valid_i) begin
                a_d     = a_i;
                b_d     = b_i;
                carry_d = cin_i;
                sel_d   = sel_i;
                cnt_d   = '0;
                state_d = BUSY;
            end
        end else if (state_q == BUSY) begin
            if (is_shift(sel_q)) begin
                f_d     = shift_val;
                cout_d  = sel_q[2] ? a_q[WIDTH-1] : a_q[0];
                zero_d  = shift_val == '0;
                ovf_d   = 1'b0;
                state_d = DONE;
            end else begin
                res_d   = res_next;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                carry_d = bit_c;
                cnt_d   = cnt_q + CW'(1);
                if (last_bit) begin
                    f_d     = res_next;
                    cout_d  = is_arith(sel_q) & bit_c;
                    ovf_d   = is_arith(sel_q) & (carry_q ^ bit_c);
                    zero_d  = res_next == '0;
                    state_d = DONE;
                end
            end
        end else if (out_ready_i) begin
            state_d = IDLE;
        end
    end

    // state and datapath registers with synchronous reset taking priority
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
            carry_q <= 1'b0;
            f_q     <= '0;
            cout_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            f_q     <= f_d;
            cout_q  <= cout_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready_o  = state_q == IDLE;
    assign out_valid_o = state_q == DONE;
    assign f_o         = f_q;
    assign cout_o      = cout_q;
    assign zero_o      = zero_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_alu_serial.sv
// tb_alu_serial: random and directed stimulus checked against a behavioural ALU model
module tb_alu_serial;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_i = 1'b1;
    logic         in_valid_i = 1'b0;
    logic         in_ready_o;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         cin_i = 1'b0;
    logic [3:0]   sel_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b0;
    logic [W-1:0] f_o;
    logic         cout_o, zero_o, ovf_o;

    int total = 0;
    int passed = 0;

    alu_serial #(.WIDTH(W)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .a_i        (a_i),
        .b_i        (b_i),
        .cin_i      (cin_i),
        .sel_i      (sel_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .f_o        (f_o),
        .cout_o     (cout_o),
        .zero_o     (zero_o),
        .ovf_o      (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // result packed as {ovf, zero, cout, f}
    function automatic logic [10:0] ref_op(input logic [7:0] a, input logic [7:0] b,
                                           input logic c, input logic [3:0] s);
        logic [7:0] y, f;
        logic [8:0] sum;
        logic co, ov;
        co = 1'b0;
        ov = 1'b0;
        f  = '0;
        y  = '0;
        if (s[3]) begin
            f  = s[2] ? {a[6:0], 1'b0} : {1'b0, a[7:1]};
            co = s[2] ? a[7] : a[0];
        end else if (s[2]) begin
            case (s[1:0])
                2'd0:    f = a & b;
                2'd1:    f = a | b;
                2'd2:    f = a ^ b;
                default: f = ~a;
            endcase
        end else begin
            case (s[1:0])
                2'd0:    y = 8'h00;
                2'd1:    y = b;
                2'd2:    y = ~b;
                default: y = 8'hFF;
            endcase
            sum = {1'b0, a} + {1'b0, y} + {8'b0, c};
            f   = sum[7:0];
            co  = sum[8];
            ov  = (a[7] == y[7]) && (f[7] != a[7]);
        end
        return {ov, f == 8'h00, co, f};
    endfunction

    int          m_ph = 0;
    int          m_left = 0;
    logic [10:0] m_out = '0;
    logic [10:0] m_pend = '0;

    always @(posedge clk) begin
        if (rst_i) begin
            m_ph  = 0;
            m_out = '0;
        end else if (m_ph == 0) begin
            if (in_valid_i) begin
                m_pend = ref_op(a_i, b_i, cin_i, sel_i);
                m_left = sel_i[3] ? 1 : W;
                m_ph   = 1;
            end
        end else if (m_ph == 1) begin
            m_left--;
            if (m_left == 0) begin
                m_ph  = 2;
                m_out = m_pend;
            end
        end else if (out_ready_i) begin
            m_ph = 0;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", 64'(in_ready_o), 64'(m_ph == 0));
        chk("out_valid", 64'(out_valid_o), 64'(m_ph == 2));
        chk("f", 64'(f_o), 64'(m_out[7:0]));
        chk("cout", 64'(cout_o), 64'(m_out[8]));
        chk("zero", 64'(zero_o), 64'(m_out[9]));
        chk("ovf", 64'(ovf_o), 64'(m_out[10]));
    end

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                         input logic [3:0] s, input int hold, input logic noise,
                         output logic [10:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 64'(n < 40), 64'd1);
        a_i = a;
        b_i = b;
        cin_i = c;
        sel_i = s;
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        a_i = 8'($urandom);
        b_i = 8'($urandom);
        cin_i = 1'($urandom);
        sel_i = 4'($urandom);
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            if (noise) in_valid_i = 1'($urandom);
            @(negedge clk);
            lat++;
        end
        res = {ovf_o, zero_o, cout_o, f_o};
        for (int i = 0; i < hold; i++) begin
            if (noise) in_valid_i = 1'($urandom);
            @(negedge clk);
            chk("hold", 64'({ovf_o, zero_o, cout_o, f_o, out_valid_o, in_ready_o}), 64'({res, 2'b10}));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        @(negedge clk);
        out_ready_i = 1'b0;
        chk("released", 64'({out_valid_o, in_ready_o}), 64'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [10:0] r;
        int          lat;
        logic [7:0]  ra, rb;
        logic        rc;
        logic [3:0]  rs;
        repeat (3) @(negedge clk);
        chk("reset_state", 64'({in_ready_o, out_valid_o, f_o, cout_o, zero_o, ovf_o}), 64'({2'b10, 8'h00, 3'b000}));
        rst_i = 1'b0;
        chk("pin_model_add", 64'(ref_op(8'hFF, 8'h01, 1'b0, 4'b0001)), 64'({3'b011, 8'h00}));
        chk("pin_model_shl", 64'(ref_op(8'h81, 8'h00, 1'b0, 4'b1100)), 64'({3'b001, 8'h02}));
        do_op(8'hFF, 8'h01, 1'b0, 4'b0001, 0, 1'b0, r, lat);
        chk("add_ff_res", 64'(r), 64'({3'b011, 8'h00}));
        chk("add_ff_lat", 64'(lat), 64'd8);
        do_op(8'h7F, 8'h01, 1'b0, 4'b0001, 1, 1'b0, r, lat);
        chk("add_ovf_res", 64'(r), 64'({3'b100, 8'h80}));
        do_op(8'h05, 8'h07, 1'b1, 4'b0010, 0, 1'b0, r, lat);
        chk("sub_res", 64'(r), 64'({3'b000, 8'hFE}));
        do_op(8'h00, 8'h5A, 1'b0, 4'b0011, 0, 1'b0, r, lat);
        chk("dec_res", 64'(r), 64'({3'b000, 8'hFF}));
        do_op(8'h81, 8'h00, 1'b0, 4'b1100, 0, 1'b0, r, lat);
        chk("shl_res", 64'(r), 64'({3'b001, 8'h02}));
        chk("shl_lat", 64'(lat), 64'd1);
        do_op(8'h81, 8'h00, 1'b0, 4'b1000, 2, 1'b0, r, lat);
        chk("shr_res", 64'(r), 64'({3'b001, 8'h40}));
        chk("shr_lat", 64'(lat), 64'd1);
        do_op(8'hF0, 8'h3C, 1'b1, 4'b0110, 3, 1'b1, r, lat);
        chk("xor_res", 64'(r), 64'({3'b000, 8'hCC}));
        chk("xor_lat", 64'(lat), 64'd8);
        repeat (4) @(negedge clk);
        chk("no_extra_result", 64'(out_valid_o), 64'd0);
        a_i = 8'h12;
        b_i = 8'h34;
        cin_i = 1'b0;
        sel_i = 4'b0001;
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        repeat (4) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        chk("abort_state", 64'({out_valid_o, in_ready_o, f_o}), 64'({2'b01, 8'h00}));
        repeat (12) @(negedge clk);
        chk("abort_quiet", 64'(out_valid_o), 64'd0);
        do_op(8'h12, 8'h34, 1'b0, 4'b0001, 0, 1'b0, r, lat);
        chk("after_abort_res", 64'(r), 64'({3'b000, 8'h46}));
        for (int k = 0; k < 200; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 4'($urandom);
            do_op(ra, rb, rc, rs, $urandom_range(0, 3), 1'b1, r, lat);
            chk("rand_res", 64'(r), 64'(ref_op(ra, rb, rc, rs)));
            chk("rand_lat", 64'(lat), rs[3] ? 64'd1 : 64'd8);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_serial.md
ALU_SERIAL -- requirements
Module: alu_serial

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width in bits; legal range 2..64.
REQ-002 clk_i  input  1  single clock; all state changes on rising edge.
REQ-003 rst_i  input  1  reset; synchronous and active-high.
REQ-004 in_valid_i  input  1  operation request.
REQ-005 in_ready_o  output  1  block can accept a request.
REQ-006 a_i  input  WIDTH  operand A.
REQ-007 b_i  input  WIDTH  operand B.
REQ-008 cin_i  input  1  carry-in, arithmetic ops only.
REQ-009 sel_i  input  4  opcode.
REQ-010 out_valid_o  output  1  result valid.
REQ-011 out_ready_i  input  1  consumer takes result.
REQ-012 f_o  output  WIDTH  result.
REQ-013 cout_o  output  1  carry/shifted-out bit.
REQ-014 zero_o  output  1  f_o == 0.
REQ-015 ovf_o  output  1  signed overflow.

Function
REQ-016 Opcodes SHALL be: 0000 A+cin; 0001 A+B+cin; 0010 A+~B+cin; 0011 A+all-ones+cin (A-1+cin); 0100 A&B; 0101 A|B; 0110 A^B; 0111 ~A; 10xx shift right (MSB fill 0); 11xx shift left (LSB fill 0).
REQ-017 FSM SHALL have states IDLE, BUSY, DONE; in_ready_o = 1 only in IDLE.
REQ-018 Accept occurs on the edge where in_valid_i & in_ready_o; a_i, b_i, cin_i, sel_i are captured then and subsequent input changes are ignored until the next accept.
REQ-019 Arithmetic/logic ops SHALL be computed bit-serially, LSB first, one bit per cycle in BUSY, carry held in a register seeded with captured cin (logic ops ignore carry).
REQ-020 Arithmetic/logic latency: accept at edge 0, bits processed on edges 1..WIDTH, out_valid_o high from edge WIDTH.
REQ-021 Shift ops SHALL complete in one BUSY cycle: out_valid_o high from edge 1.
REQ-022 Bit counter SHALL be $clog2(WIDTH) bits, cleared on accept, BUSY exits when counter reaches WIDTH-1.
REQ-023 cout_o: arithmetic = final carry out of MSB; shr = A[0]; shl = A[WIDTH-1]; logic = 0.
REQ-024 ovf_o: arithmetic = carry into MSB XOR carry out of MSB; logic/shift = 0.
REQ-025 zero_o = (f_o == 0) for all ops, valid whenever out_valid_o = 1.
REQ-026 DONE SHALL hold out_valid_o, f_o, cout_o, zero_o, ovf_o stable until an edge with out_ready_i = 1, then go to IDLE; out_ready_i high in the first DONE cycle yields a one-cycle pulse.
REQ-027 No new accept in the DONE->IDLE cycle (in_ready_o rises the cycle after release); in_valid_i in BUSY/DONE SHALL be ignored, not queued.
REQ-028 Outside DONE, out_valid_o = 0; f_o/flags retain their last values between operations.

Reset
REQ-029 rst_i high at an edge SHALL force IDLE, f_o = 0, cout_o = 0, zero_o = 0, ovf_o = 0, out_valid_o = 0, counter and carry = 0, regardless of state.
REQ-030 Reset mid-operation SHALL abort it with no out_valid_o pulse; in_ready_o = 1 in the first cycle after rst_i falls.
REQ-031 rst_i has priority over in_valid_i and out_ready_i on the same edge.

Structure
REQ-032 Shared package alu_pkg SHALL hold opcode constants and the FSM state enum (IDLE, BUSY, DONE).
REQ-033 The per-bit datapath SHALL be the existing 1-bit slice alu_1bit (a_i, b_i, cin_i, sel_i, f_o, cout_o) instantiated once; shift handling, shift register, counter and FSM live in alu_serial.

Verification (WIDTH = 8)
REQ-034 a=0xFF, b=0x01, cin=0, sel=0001 -> f=0x00, cout=1, zero=1, ovf=0, out_valid_o high 8 edges after accept.
REQ-035 a=0x7F, b=0x01, cin=0, sel=0001 -> f=0x80, cout=0, ovf=1; then a=0x05, b=0x07, cin=1, sel=0010 -> f=0xFE, cout=0, ovf=0; then a=0x00, cin=0, sel=0011 -> f=0xFF, cout=0.
REQ-036 a=0x81, sel=1100 -> f=0x02, cout=1, out_valid_o high 1 edge after accept; sel=1000 -> f=0x40, cout=1.
REQ-037 a=0xF0, b=0x3C, sel=0110 -> f=0xCC, cout=0, ovf=0; out_ready_i low 3 DONE cycles -> outputs held, in_ready_o=0, in_valid_i pulses during BUSY/DONE produce no extra result.
REQ-038 rst_i pulsed at bit 4 of an ADD -> next cycle out_valid_o=0, f_o=0, in_ready_o=1; no result for the aborted op; following op completes correctly.
